// File: rtl/key_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
// Holds the per-channel FSM state encoding and the counter sizing helper.
package key_debouncer_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_e;

    // 20 ms worth of samples at the 50 MHz fabric clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, polarity normalisation and a
// STABLE/PENDING debounce FSM with registered level and edge strobes.
module debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int                CNT_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0]       sync_q, sync_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_state_q, key_state_d;
    logic             key_press_q, key_press_d;
    logic             key_release_q, key_release_d;
    logic             sample;

    assign sample = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    always_comb begin
        sync_d        = {sync_q[0], key_in};
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_state_d   = key_state_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (sample != key_state_q) begin
                    state_d = PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PENDING: begin
                // A sample matching the current level is a bounce: drop the candidate.
                if (sample == key_state_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = STABLE;
                    cnt_d         = '0;
                    key_state_d   = sample;
                    key_press_d   = sample;
                    key_release_d = ~sample;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= {2{IDLE_LEVEL}};
            state_q       <= STABLE;
            cnt_q         <= '0;
            key_state_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_state   = key_state_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces the raw KEY pins into clean active-high levels plus one-cycle
// press/release strobes; each channel is an independent debounce_channel.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .key_in     (key_in[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule
